ysyx_22050612_regfile_mp: RTL
=============================

# ysyx_22050612_regfile_mp

Multi-ported, parametrised general-purpose register file with an integrated busy-bit scoreboard for the pipelined NPC core. It replaces the single-write/two-read register file: N read ports, M write ports, hardwired-zero register, optional write-to-read bypass, and asynchronous clear. Decode reads operands and allocates destinations. Writeback commits results and releases destinations.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 64, register width
- NREAD, 2, number of read ports (1..4)
- NWRITE, 1, number of write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/allocations
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wen  in  NWRITE  per-port write enable
- waddr  in  NWRITE*ADDR_WIDTH  write index, port k in slice k
- wdata  in  NWRITE*DATA_WIDTH  write data, port k in slice k
- raddr  in  NREAD*ADDR_WIDTH  read index per port
- rdata  out  NREAD*DATA_WIDTH  read data per port
- rvalid  out  NREAD  1 = operand ready (not busy, or bypassed this cycle)
- alloc_en  in  1  mark alloc_addr busy (instruction issued with destination)
- alloc_addr  in  ADDR_WIDTH  destination being allocated
- flush  in  1  synchronous clear of all busy bits (pipeline flush)
- busy  out  2**ADDR_WIDTH  scoreboard vector, bit i = register i has a pending write

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops, plus 2**ADDR_WIDTH busy bits.
- Write: on posedge, for each k with wen[k], reg[waddr_k] <= wdata_k. Two ports same index: higher port index wins.
- Write releases the register: busy[waddr_k] cleared.
- Allocate: alloc_en sets busy[alloc_addr] on posedge.
- Same register allocated and written in one cycle: set wins (busy=1); data still written.
- flush: all busy bits cleared; overrides alloc_en and writes to busy. Data writes in that cycle still commit.
- ZERO_REG=1: writes/allocations to index 0 dropped; raddr=0 gives rdata=0, rvalid=1; busy[0] constant 0.
- Read, BYPASS=1: if any wen[k] with waddr_k==raddr_j (highest k wins), rdata_j = wdata_k, rvalid_j=1; else stored value, rvalid_j = !busy[raddr_j].
- Read, BYPASS=0: stored value only; rvalid_j = !busy[raddr_j].
- No debug printing in RTL.

## Timing
- Reads and rvalid combinational from raddr/wen/waddr/wdata/busy; zero cycle latency.
- Write/alloc/flush effects visible to non-bypassed reads the cycle after the edge.
- rst_n low: immediately (no clock) all registers = 0, all busy = 0; hence rdata = 0, rvalid = all 1, busy = 0. Holds while low.
- Reset deassertion mid-operation: first edge after release performs normal updates; pending allocations lost by design.
- Priority on busy[i] per edge: flush > alloc > write-release > hold.

## Structure
- Package ysyx_22050612_rf_pkg: default ADDR_WIDTH/DATA_WIDTH, reset value constant (0), zero-register index constant.
- Sub-module ysyx_22050612_scoreboard: busy-bit array with alloc, multi-port release, flush, async reset, ZERO_REG masking. Data array, bypass muxes and priority encode stay in the top.

## Test plan
- Reset: write 0xDEAD to r5, assert rst_n=0 between edges -> rdata(r5)=0 at once, busy=0, rvalid=all 1.
- Write/read + bypass: wen, waddr=3, wdata=0x1234, raddr0=3 same cycle -> BYPASS=1: rdata0=0x1234; BYPASS=0: old value, then 0x1234 next cycle.
- Zero reg: write 0xFFFF to r0, alloc r0 -> rdata(r0)=0, rvalid=1, busy[0]=0.
- Scoreboard: alloc r7 -> next cycle rvalid=0 on raddr=7; write r7=0x55 -> same cycle rvalid=1 with 0x55 (BYPASS=1), next cycle busy[7]=0.
- Simultaneous: alloc r9 and write r9=0x77 same edge -> rdata(r9)=0x77, busy[9]=1; then flush -> busy=0.
- NWRITE=2 collision: both ports write r4 (0x11 port0, 0x22 port1) -> r4=0x22, bypassed read shows 0x22.

Source files
------------

// File: rtl/ysyx_22050612_rf_pkg.sv
// Shared constants for the multi-ported register file and its scoreboard.
// Holds default geometry, the reset data value and the hardwired-zero index.
package ysyx_22050612_rf_pkg;

    localparam int RF_DEF_ADDR_WIDTH = 5;
    localparam int RF_DEF_DATA_WIDTH = 64;
    localparam int RF_ZERO_IDX       = 0;
    localparam logic [63:0] RF_RESET_VAL = 64'h0;

endpackage

// File: rtl/ysyx_22050612_scoreboard.sv
// Busy-bit array: alloc sets, writeback releases, flush clears; one-edge update.
// Latency 1 cycle for all effects; no backpressure, every request is taken.
module ysyx_22050612_scoreboard
    import ysyx_22050612_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_DEF_ADDR_WIDTH,
    parameter int NWRITE     = 1,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NWRITE-1:0]            wen,
    input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
    input  logic                         alloc_en,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    input  logic                         flush,
    output logic [2**ADDR_WIDTH-1:0]     busy
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;

    // Applied lowest priority first so later statements override: release < alloc < flush.
    always_comb begin
        busy_nxt = busy_q;
        for (int k = 0; k < NWRITE; k++) begin
            if (wen[k]) begin
                busy_nxt[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        if (ZERO_REG) begin
            busy_nxt[RF_ZERO_IDX] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/ysyx_22050612_regfile_mp.sv
// N-read / M-write register file with busy scoreboard, optional bypass and zero register.
// Reads are combinational (0 cycles); writes visible next cycle; no backpressure.
module ysyx_22050612_regfile_mp
    import ysyx_22050612_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DEF_DATA_WIDTH,
    parameter int NREAD      = 2,
    parameter int NWRITE     = 1,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NWRITE-1:0]            wen,
    input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
    input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
    input  logic [NREAD*ADDR_WIDTH-1:0]  raddr,
    output logic [NREAD*DATA_WIDTH-1:0]  rdata,
    output logic [NREAD-1:0]             rvalid,
    input  logic                         alloc_en,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    input  logic                         flush,
    output logic [2**ADDR_WIDTH-1:0]     busy
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);
    localparam logic [DATA_WIDTH-1:0] RST_VAL  = DATA_WIDTH'(RF_RESET_VAL);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy_vec;

    ysyx_22050612_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NWRITE     (NWRITE),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (wen),
        .waddr      (waddr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy       (busy_vec)
    );

    assign busy = busy_vec;

    // Ports are walked in ascending order so the highest-indexed writer lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wen[k] && !(ZERO_REG && waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ZERO_IDX)) begin
                    regs[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rdata  = '0;
        rvalid = '0;
        for (int j = 0; j < NREAD; j++) begin
            logic [ADDR_WIDTH-1:0] idx;
            logic [DATA_WIDTH-1:0] val;
            logic                  ok;
            idx = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
            val = regs[idx];
            ok  = !busy_vec[idx];
            if (BYPASS) begin
                for (int k = 0; k < NWRITE; k++) begin
                    if (wen[k] && waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == idx) begin
                        val = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                        ok  = 1'b1;
                    end
                end
            end
            // Zero register wins even over a same-cycle bypass, since that write is dropped.
            if (ZERO_REG && idx == ZERO_IDX) begin
                val = '0;
                ok  = 1'b1;
            end
            rdata[j*DATA_WIDTH +: DATA_WIDTH] = val;
            rvalid[j] = ok;
        end
    end

endmodule
